// File: rtl/fde_pkg.sv
// Shared definitions for the frame-decider / texture path.
//   TEX_AW, TEX_DW : texture address and data widths seen by the requesters
//   PORT_DECIDER   : port id of the frame-buffer decider (sprite fetch)
//   PORT_SCORE     : port id of the score/digit renderer
//   tex_tag_t      : per-read tag carried alongside the ROM access
package fde_pkg;

   localparam int TEX_AW = 16;
   localparam int TEX_DW = 8;

   localparam logic PORT_DECIDER = 1'b0;
   localparam logic PORT_SCORE   = 1'b1;

   typedef struct packed {
      logic valid;   // a read was accepted into this slot
      logic port;    // which requester owns the returning data
      logic oor;     // address was outside the ROM; return FILL instead
   } tex_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with burst lock.
//   clk, rstn  : clock, asynchronous active-low reset
//   req[1:0]   : request per port
//   lock[1:0]  : burst lock per port, only meaningful for the port being granted
//   gnt[1:0]   : combinational one-hot (or zero) grant
// Under contention the port that did not win last time is granted, unless a
// port holds the lock, in which case it keeps winning until it drops lock or req.
module rr_arb2 (
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] req,
   input  logic [1:0] lock,
   output logic [1:0] gnt
);

   logic       last_reg, last_next;
   logic       owned_reg, owned_next;
   logic       owner_reg, owner_next;
   logic       owner_live;
   logic [1:0] gnt_raw;
   logic       gnt_port;

   always_comb begin
      gnt_raw    = 2'b00;
      // A lock only counts while its owner is still asking and still locking;
      // the cycle either drops, the other port competes normally again.
      owner_live = owned_reg && req[owner_reg] && lock[owner_reg];
      if (req == 2'b11) begin
         if (owner_live) gnt_raw[owner_reg] = 1'b1;
         else            gnt_raw[~last_reg] = 1'b1;
      end else begin
         gnt_raw = req;
      end
   end

   // Nothing is accepted while reset is held.
   assign gnt      = gnt_raw & {2{rstn}};
   assign gnt_port = gnt_raw[1];

   always_comb begin
      last_next  = last_reg;
      owned_next = 1'b0;
      owner_next = owner_reg;
      if (|gnt_raw) begin
         last_next  = gnt_port;
         owned_next = lock[gnt_port];
         owner_next = gnt_port;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_reg  <= 1'b1;   // port 0 wins the first contention
         owned_reg <= 1'b0;
         owner_reg <= 1'b0;
      end else begin
         last_reg  <= last_next;
         owned_reg <= owned_next;
         owner_reg <= owner_next;
      end
   end

endmodule

// File: rtl/texture_rom_arbiter.sv
// Shares the single-port texture ROM between the frame-buffer decider (port 0)
// and the score/digit renderer (port 1).
//   clk, rstn                        : system clock, asynchronous active-low reset
//   reqX_i, lockX_i, addrX_i         : read request, burst lock, texture address
//   gntX_o                           : request accepted this cycle (combinational)
//   rvalidX_o, rdataX_o              : one-cycle return pulse and held read data
//   rom_addr_o, rom_data_i           : registered ROM address, ROM read data
//   oor_o                            : sticky, an out-of-range address was accepted
// A read accepted in cycle N returns on its own port in cycle N+2+ROM_LAT.
module texture_rom_arbiter
   import fde_pkg::*;
#(
   parameter int                ROM_AW    = 10,
   parameter int                ROM_DEPTH = 1024,
   parameter int                ROM_LAT   = 0,
   parameter logic [TEX_DW-1:0] FILL      = 8'h00
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req0_i,
   input  logic              lock0_i,
   input  logic [TEX_AW-1:0] addr0_i,
   output logic              gnt0_o,
   output logic              rvalid0_o,
   output logic [TEX_DW-1:0] rdata0_o,
   input  logic              req1_i,
   input  logic              lock1_i,
   input  logic [TEX_AW-1:0] addr1_i,
   output logic              gnt1_o,
   output logic              rvalid1_o,
   output logic [TEX_DW-1:0] rdata1_o,
   output logic [ROM_AW-1:0] rom_addr_o,
   input  logic [TEX_DW-1:0] rom_data_i,
   output logic              oor_o
);

   logic [1:0]        gnt;
   logic              accepted;
   logic              sel;
   logic [TEX_AW-1:0] sel_addr;
   logic              sel_oor;
   tex_tag_t          tag_pipe [ROM_LAT+1];
   tex_tag_t          head;
   logic [TEX_DW-1:0] ret_data;

   rr_arb2 u_arb (
      .clk  (clk),
      .rstn (rstn),
      .req  ({req1_i, req0_i}),
      .lock ({lock1_i, lock0_i}),
      .gnt  (gnt)
   );

   assign gnt0_o   = gnt[0];
   assign gnt1_o   = gnt[1];
   assign accepted = |gnt;
   assign sel      = gnt[1];
   assign sel_addr = sel ? addr1_i : addr0_i;
   // Full-width compare so stray upper bits beyond ROM_AW also count as out of range.
   assign sel_oor  = 32'(sel_addr) >= 32'(ROM_DEPTH);

   // Issue register and sticky range flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rom_addr_o <= '0;
         oor_o      <= 1'b0;
      end else begin
         if (accepted) rom_addr_o <= sel_addr[ROM_AW-1:0];
         oor_o <= oor_o | (accepted & sel_oor);
      end
   end

   // Tag pipe: the tag leaves the last stage in the same cycle the ROM data for
   // that address is valid, so the return registers capture both together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i <= ROM_LAT; i++) tag_pipe[i] <= '0;
      end else begin
         tag_pipe[0] <= '{valid: accepted, port: sel, oor: sel_oor};
         for (int i = ROM_LAT; i > 0; i--) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   assign head     = tag_pipe[ROM_LAT];
   assign ret_data = head.oor ? FILL : rom_data_i;

   // Return registers: data holds between pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rvalid0_o <= 1'b0;
         rvalid1_o <= 1'b0;
         rdata0_o  <= '0;
         rdata1_o  <= '0;
      end else begin
         rvalid0_o <= head.valid && (head.port == PORT_DECIDER);
         rvalid1_o <= head.valid && (head.port == PORT_SCORE);
         if (head.valid && (head.port == PORT_DECIDER)) rdata0_o <= ret_data;
         if (head.valid && (head.port == PORT_SCORE))   rdata1_o <= ret_data;
      end
   end

endmodule

// File: tb/tb_texture_rom_arbiter.sv
module tb_texture_rom_arbiter;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
   logic [15:0] addr0 = '0, addr1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, oor;
   logic [7:0]  rdata0, rdata1, rom_data;
   logic [9:0]  rom_addr;

   always #5 clk = ~clk;

   // Texture ROM contents as a closed-form function of the word address.
   function automatic logic [7:0] rom_f(input logic [9:0] a);
      logic [15:0] t;
      t = {6'b0, a} * 16'd37 + 16'd11;
      return t[7:0] ^ {a[9:8], 6'b0};
   endfunction

   assign rom_data = rom_f(rom_addr);

   texture_rom_arbiter dut (
      .clk        (clk),
      .rstn       (rstn),
      .req0_i     (req0),
      .lock0_i    (lock0),
      .addr0_i    (addr0),
      .gnt0_o     (gnt0),
      .rvalid0_o  (rvalid0),
      .rdata0_o   (rdata0),
      .req1_i     (req1),
      .lock1_i    (lock1),
      .addr1_i    (addr1),
      .gnt1_o     (gnt1),
      .rvalid1_o  (rvalid1),
      .rdata1_o   (rdata1),
      .rom_addr_o (rom_addr),
      .rom_data_i (rom_data),
      .oor_o      (oor)
   );

   typedef struct packed {
      logic        rs;
      logic        r0;
      logic        l0;
      logic [15:0] a0;
      logic        r1;
      logic        l1;
      logic [15:0] a1;
   } stim_t;

   typedef struct {
      int         due;
      int         port;
      logic [7:0] data;
   } ret_t;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model state: outstanding returns keyed by due cycle, arbitration memory.
   ret_t       pend[$];
   int         m_last, m_owner;
   logic       m_oor;
   logic [7:0] m_rd0, m_rd1;
   logic [9:0] m_rom_addr;

   logic [1:0]  exp_gnt, exp_rv;
   logic [15:0] exp_rd;
   logic        exp_oor;
   logic [9:0]  exp_ra;

   function automatic stim_t mk(input logic rs, input logic r0, input logic l0, input logic [15:0] a0,
                                input logic r1, input logic l1, input logic [15:0] a1);
      stim_t s;
      s = '{rs: rs, r0: r0, l0: l0, a0: a0, r1: r1, l1: l1, a1: a1};
      return s;
   endfunction

   task automatic model_reset();
      pend.delete();
      m_last     = 1;
      m_owner    = -1;
      m_oor      = 1'b0;
      m_rd0      = 8'h00;
      m_rd1      = 8'h00;
      m_rom_addr = '0;
   endtask

   // Drives one cycle of stimulus, then at the falling edge produces the
   // expected outputs for that cycle and advances the model.
   task automatic cycle(input stim_t s);
      int          g;
      logic [15:0] a;
      logic        lk[2];
      @(posedge clk);
      #1;
      cyc++;
      rstn = s.rs; req0 = s.r0; lock0 = s.l0; addr0 = s.a0;
      req1 = s.r1; lock1 = s.l1; addr1 = s.a1;
      if (!s.rs) model_reset();
      @(negedge clk);
      exp_rv = 2'b00;
      while (pend.size() > 0 && pend[0].due == cyc) begin
         ret_t e;
         e = pend.pop_front();
         exp_rv[e.port] = 1'b1;
         if (e.port == 0) m_rd0 = e.data;
         else             m_rd1 = e.data;
      end
      exp_rd  = {m_rd1, m_rd0};
      exp_oor = m_oor;
      exp_ra  = m_rom_addr;
      lk[0] = s.l0;
      lk[1] = s.l1;
      g = -1;
      if (s.rs) begin
         if (s.r0 && s.r1) g = (m_owner >= 0 && lk[m_owner]) ? m_owner : 1 - m_last;
         else if (s.r0)    g = 0;
         else if (s.r1)    g = 1;
      end
      exp_gnt = 2'b00;
      if (g >= 0) begin
         exp_gnt[g] = 1'b1;
         a = (g == 1) ? s.a1 : s.a0;
         pend.push_back('{cyc + 2, g, (a >= 16'd1024) ? 8'h00 : rom_f(a[9:0])});
         m_last     = g;
         m_oor      = m_oor | (a >= 16'd1024);
         m_rom_addr = a[9:0];
         m_owner    = lk[g] ? g : -1;
         $display("[TB] cyc %0d grant port %0d addr %h", cyc, g, a);
      end else begin
         m_owner = -1;
      end
   endtask

   task automatic test_reset();
      stim_t sq[$];
      repeat (3) sq.push_back(mk(0, 1, 0, 16'h0001, 0, 0, 16'h0000));
      sq.push_back(mk(1, 1, 0, 16'h0001, 0, 0, 16'h0000));
      repeat (3) sq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000));
      foreach (sq[i]) begin
         cycle(sq[i]);
         tests++;
         if ({gnt1, gnt0} !== exp_gnt) begin
            fails++; $display("FAIL reset_gnt cyc %0d got %b want %b", cyc, {gnt1, gnt0}, exp_gnt);
         end
         tests++;
         if ({rvalid1, rvalid0, rdata1, rdata0} !== {exp_rv, exp_rd}) begin
            fails++; $display("FAIL reset_ret cyc %0d got %h want %h", cyc, {rvalid1, rvalid0, rdata1, rdata0}, {exp_rv, exp_rd});
         end
         tests++;
         if ({oor, rom_addr} !== {exp_oor, exp_ra}) begin
            fails++; $display("FAIL reset_status cyc %0d got %h want %h", cyc, {oor, rom_addr}, {exp_oor, exp_ra});
         end
         if (i == 5) begin
            tests++;
            if (rvalid0 !== 1'b1 || rdata0 !== rom_f(10'h001)) begin
               fails++; $display("FAIL reset_first_return cyc %0d got %b/%h want 1/%h", cyc, rvalid0, rdata0, rom_f(10'h001));
            end
         end
      end
   endtask

   task automatic test_single_port();
      stim_t sq[$];
      sq.push_back(mk(1, 1, 0, 16'h0005, 0, 0, 16'h0000));
      sq.push_back(mk(1, 1, 0, 16'h0006, 0, 0, 16'h0000));
      sq.push_back(mk(1, 1, 0, 16'h0007, 0, 0, 16'h0000));
      repeat (3) sq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000));
      foreach (sq[i]) begin
         cycle(sq[i]);
         tests++;
         if ({gnt1, gnt0} !== exp_gnt) begin
            fails++; $display("FAIL single_gnt cyc %0d got %b want %b", cyc, {gnt1, gnt0}, exp_gnt);
         end
         tests++;
         if ({rvalid1, rvalid0, rdata1, rdata0} !== {exp_rv, exp_rd}) begin
            fails++; $display("FAIL single_ret cyc %0d got %h want %h", cyc, {rvalid1, rvalid0, rdata1, rdata0}, {exp_rv, exp_rd});
         end
         tests++;
         if ({oor, rom_addr} !== {exp_oor, exp_ra}) begin
            fails++; $display("FAIL single_status cyc %0d got %h want %h", cyc, {oor, rom_addr}, {exp_oor, exp_ra});
         end
      end
   endtask

   task automatic test_contention();
      stim_t sq[$];
      logic [1:0] prev;
      int alt_bad;
      prev = 2'b00;
      alt_bad = 0;
      repeat (8) sq.push_back(mk(1, 1, 0, 16'($urandom_range(0, 1023)), 1, 0, 16'($urandom_range(0, 1023))));
      repeat (3) sq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000));
      foreach (sq[i]) begin
         cycle(sq[i]);
         if (i > 0 && i < 8 && {gnt1, gnt0} !== ~prev) alt_bad++;
         prev = {gnt1, gnt0};
         tests++;
         if ({gnt1, gnt0} !== exp_gnt) begin
            fails++; $display("FAIL contention_gnt cyc %0d got %b want %b", cyc, {gnt1, gnt0}, exp_gnt);
         end
         tests++;
         if ({rvalid1, rvalid0, rdata1, rdata0} !== {exp_rv, exp_rd}) begin
            fails++; $display("FAIL contention_ret cyc %0d got %h want %h", cyc, {rvalid1, rvalid0, rdata1, rdata0}, {exp_rv, exp_rd});
         end
      end
      tests++;
      if (alt_bad !== 0) begin
         fails++; $display("FAIL contention_alternate got %0d non-alternating cycles want 0", alt_bad);
      end
   endtask

   task automatic test_lock();
      stim_t sq[$];
      int n1;
      n1 = 0;
      sq.push_back(mk(1, 1, 0, 16'h0020, 0, 0, 16'h0000));
      for (int k = 0; k < 4; k++) sq.push_back(mk(1, 1, 0, 16'h0021, 1, 1, 16'(16'h0030 + k)));
      sq.push_back(mk(1, 1, 0, 16'h0021, 1, 0, 16'h0034));
      repeat (3) sq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000));
      foreach (sq[i]) begin
         cycle(sq[i]);
         if (i >= 1 && i <= 4 && gnt1 === 1'b1 && gnt0 === 1'b0) n1++;
         if (i == 5) begin
            tests++;
            if ({gnt1, gnt0} !== 2'b01) begin
               fails++; $display("FAIL lock_release cyc %0d got %b want 01", cyc, {gnt1, gnt0});
            end
         end
         tests++;
         if ({gnt1, gnt0} !== exp_gnt) begin
            fails++; $display("FAIL lock_gnt cyc %0d got %b want %b", cyc, {gnt1, gnt0}, exp_gnt);
         end
         tests++;
         if ({rvalid1, rvalid0, rdata1, rdata0} !== {exp_rv, exp_rd}) begin
            fails++; $display("FAIL lock_ret cyc %0d got %h want %h", cyc, {rvalid1, rvalid0, rdata1, rdata0}, {exp_rv, exp_rd});
         end
      end
      tests++;
      if (n1 !== 4) begin
         fails++; $display("FAIL lock_hold got %0d locked grants want 4", n1);
      end
   endtask

   task automatic test_oor();
      stim_t sq[$];
      sq.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h0400));
      sq.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h8005));
      sq.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h03FF));
      repeat (3) sq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000));
      foreach (sq[i]) begin
         cycle(sq[i]);
         if (i >= 1) begin
            tests++;
            if (oor !== 1'b1) begin
               fails++; $display("FAIL oor_sticky cyc %0d got %b want 1", cyc, oor);
            end
         end
         tests++;
         if ({gnt1, gnt0} !== exp_gnt) begin
            fails++; $display("FAIL oor_gnt cyc %0d got %b want %b", cyc, {gnt1, gnt0}, exp_gnt);
         end
         tests++;
         if ({rvalid1, rvalid0, rdata1, rdata0} !== {exp_rv, exp_rd}) begin
            fails++; $display("FAIL oor_ret cyc %0d got %h want %h", cyc, {rvalid1, rvalid0, rdata1, rdata0}, {exp_rv, exp_rd});
         end
         tests++;
         if ({oor, rom_addr} !== {exp_oor, exp_ra}) begin
            fails++; $display("FAIL oor_status cyc %0d got %h want %h", cyc, {oor, rom_addr}, {exp_oor, exp_ra});
         end
      end
   endtask

   task automatic test_reset_midflight();
      stim_t sq[$];
      sq.push_back(mk(1, 1, 0, 16'h0010, 0, 0, 16'h0000));
      sq.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000));
      sq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000));
      sq.push_back(mk(1, 1, 0, 16'h0011, 0, 0, 16'h0000));
      repeat (3) sq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000));
      foreach (sq[i]) begin
         cycle(sq[i]);
         if (i == 2) begin
            tests++;
            if (rvalid0 !== 1'b0) begin
               fails++; $display("FAIL midflight_no_return cyc %0d got %b want 0", cyc, rvalid0);
            end
         end
         tests++;
         if ({gnt1, gnt0} !== exp_gnt) begin
            fails++; $display("FAIL midflight_gnt cyc %0d got %b want %b", cyc, {gnt1, gnt0}, exp_gnt);
         end
         tests++;
         if ({rvalid1, rvalid0, rdata1, rdata0} !== {exp_rv, exp_rd}) begin
            fails++; $display("FAIL midflight_ret cyc %0d got %h want %h", cyc, {rvalid1, rvalid0, rdata1, rdata0}, {exp_rv, exp_rd});
         end
         tests++;
         if ({oor, rom_addr} !== {exp_oor, exp_ra}) begin
            fails++; $display("FAIL midflight_status cyc %0d got %h want %h", cyc, {oor, rom_addr}, {exp_oor, exp_ra});
         end
      end
   endtask

   task automatic test_random();
      stim_t s;
      logic [15:0] a0, a1;
      for (int n = 0; n < 303; n++) begin
         a0 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1024, 65535)) : 16'($urandom_range(0, 1023));
         a1 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1024, 65535)) : 16'($urandom_range(0, 1023));
         if (n < 300)
            s = mk(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a0,
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a1);
         else
            s = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000);
         cycle(s);
         tests++;
         if ({gnt1, gnt0} !== exp_gnt) begin
            fails++; $display("FAIL random_gnt cyc %0d got %b want %b", cyc, {gnt1, gnt0}, exp_gnt);
         end
         tests++;
         if ({rvalid1, rvalid0, rdata1, rdata0} !== {exp_rv, exp_rd}) begin
            fails++; $display("FAIL random_ret cyc %0d got %h want %h", cyc, {rvalid1, rvalid0, rdata1, rdata0}, {exp_rv, exp_rd});
         end
         tests++;
         if ({oor, rom_addr} !== {exp_oor, exp_ra}) begin
            fails++; $display("FAIL random_status cyc %0d got %h want %h", cyc, {oor, rom_addr}, {exp_oor, exp_ra});
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_port();
      test_contention();
      test_lock();
      test_oor();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
